bf16_op_dispatch: RTL and testbench
===================================

# bf16_op_dispatch

Command queue and issue stage that sits directly upstream of the bfloat16 add/sub/mul datapath. It replaces the hard-coded operand ROM with a valid/ready command interface. It buffers commands in a FIFO and presents the head entry's operands and opcode to the combinational datapath. It then captures the returned result into a registered, tagged response port with its own valid/ready handshake.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2
- TAG_W, 4: width of the caller-supplied command tag
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  equals !full
- cmd_a  in  16  bf16 operand A
- cmd_b  in  16  bf16 operand B
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 reserved
- cmd_tag  in  TAG_W  returned unchanged with the response
- alu_a  out  16  head operand A to the datapath; 0 when FIFO empty
- alu_b  out  16  head operand B; 0 when empty
- alu_op  out  2  head opcode; 00 when empty
- alu_result  in  16  datapath result for the current alu_a/alu_b/alu_op (combinational, same cycle)
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_data  out  16  bf16 result
- rsp_tag  out  TAG_W  tag of the command
- rsp_err  out  1  command carried op 11
- count  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the response register)

## Operation
- Push: on cmd_valid && cmd_ready, write {a,b,op,tag} at wr_ptr and increment wr_ptr modulo DEPTH.
- cmd_ready depends only on full; a pop in the same cycle does not open a slot.
- Pop condition: !empty && (!rsp_valid || rsp_ready). On pop:
  - rd_ptr increments.
  - rsp_data ← alu_result, or 16'h0000 if the head op is 11.
  - rsp_tag ← head tag; rsp_err ← (op==11); rsp_valid ← 1.
- If rsp_valid && rsp_ready and there is no pop, rsp_valid ← 0. The data, tag and err fields hold their values.
- Push and pop in the same cycle: count unchanged. Entries never bypass the FIFO: a command pushed into an empty FIFO is popped on the following cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty come from count.
- Responses leave strictly in command order. No drop, no duplication.

## Timing
- Reset values: count 0, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_err 0, cmd_ready 1, alu_* 0.
- Latency: a command accepted at edge N with an empty FIFO and idle response register has rsp_valid high after edge N+1.
- Throughput: one command per cycle when rsp_ready is held high.
- Capacity: DEPTH+1 commands can be outstanding (DEPTH in the FIFO plus 1 in the response register).
- rst asserted mid-operation: all queued commands and any held response are discarded at that edge. No response is emitted for them.

## Configuration
- BF16_DISPATCH_STATS_EN defined:
  - Adds output stat_issued[15:0], counting pops and saturating at 16'hFFFF.
  - Adds output stat_illegal[7:0], counting pops with op 11 and saturating at 8'hFF.
  - Both counters are cleared by rst.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package bf16_pkg:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSVD=2'b11.
  - BF16_W=16.
  - Packed command struct {a, b, op}.
- One sub-module, bf16_sync_fifo: parameterised depth/width, with count, full and empty. It exposes the head combinationally.
- The response register and the stats logic live in the top module.

## Test plan
- Reset, then push mul a=16'h4385 (266), b=16'h4188 (17), tag 3 → rsp_valid one cycle after accept, rsp_data=16'h458D (4522), rsp_tag=3, rsp_err=0.
- rsp_ready=0, push tags 0..DEPTH → exactly DEPTH+1 accepted, cmd_ready=0, count=DEPTH. Then raise rsp_ready → tags 0..DEPTH delivered one per cycle in order, and cmd_ready returns to 1.
- Push op 11 with a=16'h4385, tag 5 → rsp_data=16'h0000, rsp_err=1, tag 5. With the macro defined, stat_illegal=1.
- Stream 20 adds 16'h44BE+16'h44D6 with rsp_ready toggling every cycle → 20 responses, each 16'h454A (3232), tags in order, none lost or repeated.
- Queue 3 commands, assert rst for one cycle → next cycle rsp_valid=0, count=0, cmd_ready=1. Then push sub 16'h4188 − 16'hC188 → rsp_data=16'h4208 (34).

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared opcode constants and command bundle for the bf16 dispatch path.
package bf16_pkg;
  localparam int BF16_W = 16;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef struct packed {
    logic [BF16_W-1:0] a;
    logic [BF16_W-1:0] b;
    logic [1:0]        op;
  } bf16_cmd_t;
endpackage

// File: rtl/bf16_op_dispatch_fifo.sv
// bf16_sync_fifo: synchronous FIFO with occupancy count and a
// combinational head. Callers gate push with !full and pop with !empty.
module bf16_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bf16_op_dispatch.sv
// Command FIFO + issue stage feeding the bf16 datapath, with a tagged
// response register. Define BF16_DISPATCH_STATS_EN for issue/illegal counters.
module bf16_op_dispatch
  import bf16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [15:0]            cmd_a,
  input  logic [15:0]            cmd_b,
  input  logic [1:0]             cmd_op,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [1:0]             alu_op,
  input  logic [15:0]            alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] count
`ifdef BF16_DISPATCH_STATS_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [7:0]             stat_illegal
`endif
);
  localparam int EW = $bits(bf16_cmd_t) + TAG_W;

  bf16_cmd_t        in_cmd;
  bf16_cmd_t        head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic [EW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_err;

  assign in_cmd.a  = cmd_a;
  assign in_cmd.b  = cmd_b;
  assign in_cmd.op = cmd_op;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = !empty && (!rsp_valid || rsp_ready);

  bf16_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({in_cmd, cmd_tag}),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign {head_cmd, head_tag} = head;

  // Park the datapath at zero while idle so it never sees stale entries.
  assign alu_a    = empty ? '0 : head_cmd.a;
  assign alu_b    = empty ? '0 : head_cmd.b;
  assign alu_op   = empty ? OP_ADD : head_cmd.op;
  assign head_err = head_cmd.op == OP_RSVD;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (pop) begin
      rsp_valid <= 1'b1;
      rsp_data  <= head_err ? '0 : alu_result;
      rsp_tag   <= head_tag;
      rsp_err   <= head_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef BF16_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else if (pop) begin
      if (stat_issued != 16'hFFFF)
        stat_issued <= stat_issued + 16'd1;
      if (head_err && stat_illegal != 8'hFF)
        stat_illegal <= stat_illegal + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bf16_op_dispatch.sv
// Bench for bf16_op_dispatch: directed plan plus randomized traffic
// against an in-order queue model of outstanding commands.
module tb_bf16_op_dispatch;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic        rsp_err;
  logic [$clog2(DEPTH):0] count;
`ifdef BF16_DISPATCH_STATS_EN
  logic [15:0] stat_issued;
  logic [7:0]  stat_illegal;
`endif

  int passed = 0;
  int total = 0;
  int hs = 0;
  logic [20:0] q[$];

  always #5 clk = ~clk;

  function automatic real bf2r(logic [15:0] x);
    logic [10:0] e;
    if (x[14:0] == '0) return 0.0;
    e = {3'b000, x[14:7]} + 11'd896;
    return $bitstoreal({x[15], e, x[6:0], 45'b0});
  endfunction

  function automatic logic [15:0] r2bf(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:45]};
  endfunction

  // Stand-in bf16 datapath (truncating); op 11 yields junk that must be masked.
  function automatic logic [15:0] dp(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    case (op)
      2'b00:   return r2bf(bf2r(a) + bf2r(b));
      2'b01:   return r2bf(bf2r(a) - bf2r(b));
      2'b10:   return r2bf(bf2r(a) * bf2r(b));
      default: return 16'hBEEF;
    endcase
  endfunction

  assign alu_result = dp(alu_a, alu_b, alu_op);

  bf16_op_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .count      (count)
`ifdef BF16_DISPATCH_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
`endif
  );

  task automatic chk(string name, int unsigned act, int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [15:0] a, logic [15:0] b, logic [1:0] op, int tag);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_tag = TAG_W'(tag);
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && (count != 0 || rsp_valid); i++) step();
    chk("drain_idle", {count, rsp_valid}, 0);
  endtask

  // Model: every accepted command is owed exactly one response, in order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("occupancy", int'(count) + int'(rsp_valid), q.size());
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          chk("rsp_fields", {rsp_err, rsp_tag, rsp_data}, q[0]);
          if (rsp_ready) begin
            void'(q.pop_front());
            hs++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_op == 2'b11) q.push_back({1'b1, cmd_tag, 16'h0000});
        else q.push_back({1'b0, cmd_tag, dp(cmd_a, cmd_b, cmd_op)});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    int hs0;
    logic ok;

    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);

    drive(16'h4385, 16'h4188, 2'b10, 3);
    step();
    cmd_valid = 1'b0;
    chk("mul_wait", {rsp_valid, count}, 1);
    chk("mul_alu", {alu_op, alu_a}, {2'b10, 16'h4385});
    step();
    chk("mul_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, {1'b1, 1'b0, 4'd3, 16'h458D});
    chk("mul_idle_alu", {alu_a, alu_b, alu_op, count}, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    t = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      drive(16'h3F80 + 16'(c), 16'h4000, 2'b00, t);
      ok = cmd_ready;
      step();
      if (ok) t++;
    end
    cmd_valid = 1'b0;
    chk("cap_accepted", t, DEPTH + 1);
    chk("cap_full", {cmd_ready, count}, DEPTH);
    rsp_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      chk("cap_order", {rsp_valid, rsp_tag}, {1'b1, 4'(i)});
      step();
    end
    chk("cap_empty", {rsp_valid, cmd_ready, count}, {1'b0, 1'b1, 4'd0});
    rsp_ready = 1'b0;

    drive(16'h4385, 16'h4188, 2'b11, 5);
    step();
    cmd_valid = 1'b0;
    step();
    chk("rsvd_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, {1'b1, 1'b1, 4'd5, 16'h0000});
`ifdef BF16_DISPATCH_STATS_EN
    chk("stat_illegal", stat_illegal, 1);
    chk("stat_issued", stat_issued, DEPTH + 3);
`endif
    drain();

    hs0 = hs;
    n = 0;
    for (int g = 0; g < 200 && n < 20; g++) begin
      drive(16'h44BE, 16'h44D6, 2'b00, n);
      rsp_ready = ~rsp_ready;
      ok = cmd_ready;
      if (rsp_valid) chk("stream_data", rsp_data, 16'h454A);
      step();
      if (ok) n++;
    end
    chk("stream_sent", n, 20);
    drain();
    chk("stream_rcvd", hs - hs0, 20);

    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h4000, 16'h4000, 2'b10, i);
      step();
    end
    cmd_valid = 1'b0;
    chk("pre_rst", {rsp_valid, count}, {1'b1, 4'd2});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst", {rsp_valid, cmd_ready, count}, {1'b0, 1'b1, 4'd0});
    drive(16'h4188, 16'hC188, 2'b01, 7);
    step();
    cmd_valid = 1'b0;
    step();
    chk("sub_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_data}, {1'b1, 1'b0, 4'd7, 16'h4208});
`ifdef BF16_DISPATCH_STATS_EN
    chk("stat_after_rst", {stat_issued, stat_illegal}, {16'd1, 8'd0});
`endif
    drain();

    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 149) == 0;
      cmd_valid = $urandom_range(0, 3) != 0;
      cmd_a = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
      cmd_b = {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
      cmd_op = 2'($urandom_range(0, 3));
      cmd_tag = TAG_W'($urandom);
      rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    rst = 1'b0;
    drain();
    step();
    chk("final_model_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
